// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard sources in, pipeline enables/flushes and status out
// The pipeline side is the master; the hazard sequencer is the slave.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic             idex_memread;
    logic [4:0]       idex_rd;
    logic             exmem_branch;
    logic             exmem_zero;
    logic             exmem_memread;
    logic             exmem_memwrite;
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             pc_src;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic             mem_timeout;
    logic [1:0]       state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, idex_memread, idex_rd,
               exmem_branch, exmem_zero, exmem_memread, exmem_memwrite, dmem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write, pc_src,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble,
               stall_cycles, flush_events, mem_timeout, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, idex_memread, idex_rd,
               exmem_branch, exmem_zero, exmem_memread, exmem_memwrite, dmem_ready,
        output pc_write, ifid_write, idex_write, exmem_write, pc_src,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble,
               stall_cycles, flush_events, mem_timeout, state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Memory wait freezes everything, taken branch flushes, load-use inserts one bubble.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01
    } state_t;

    state_t           r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;
    logic             r_mem_timeout;

    logic w_mem_busy;
    logic w_br_taken;
    logic w_load_use;
    logic w_br_act;

    logic w_pc_write;
    logic w_ifid_write;
    logic w_idex_write;
    logic w_exmem_write;
    logic w_pc_src;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_flush;
    logic w_memwb_bubble;

    assign w_mem_busy = (bus.exmem_memread | bus.exmem_memwrite) & ~bus.dmem_ready;
    assign w_br_taken = bus.exmem_branch & bus.exmem_zero;
    assign w_load_use = bus.idex_memread && (bus.idex_rd != 5'd0) &&
                        ((bus.idex_rd == bus.id_rs1) ||
                         (bus.id_uses_rs2 && (bus.idex_rd == bus.id_rs2)));
    // A branch is only acted on when memory is not holding the pipeline.
    assign w_br_act   = ~reset & ~w_mem_busy & w_br_taken;

    always_comb begin
        w_pc_write     = 1'b1;
        w_ifid_write   = 1'b1;
        w_idex_write   = 1'b1;
        w_exmem_write  = 1'b1;
        w_pc_src       = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_flush  = 1'b0;
        w_memwb_bubble = 1'b0;
        if (reset) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_write   = 1'b0;
            w_exmem_write  = 1'b0;
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_exmem_flush  = 1'b1;
            w_memwb_bubble = 1'b1;
        end else if (w_mem_busy) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_write   = 1'b0;
            w_exmem_write  = 1'b0;
            w_memwb_bubble = 1'b1;
        end else if (w_br_taken) begin
            w_pc_src       = 1'b1;
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_exmem_flush  = 1'b1;
        end else if (w_load_use) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_flush   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
            r_mem_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_busy) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_mem_busy) begin
                        // Hold at the last count so the flag cannot re-arm by wrapping.
                        if (r_wait_cnt == WC_LAST) begin
                            r_mem_timeout <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + WC_W'(1);
                        end
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase

            if (!w_pc_write && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_br_act && (r_flush_events != {CNT_W{1'b1}})) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.ifid_write   = w_ifid_write;
    assign bus.idex_write   = w_idex_write;
    assign bus.exmem_write  = w_exmem_write;
    assign bus.pc_src       = w_pc_src;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_flush   = w_idex_flush;
    assign bus.exmem_flush  = w_exmem_flush;
    assign bus.memwb_bubble = w_memwb_bubble;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
    assign bus.mem_timeout  = r_mem_timeout;
    assign bus.state        = r_state;

endmodule
